// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: default widths,
// reset PC and the fetch FSM state encoding.
package fetch_pkg;

  localparam int              FETCH_ADDR_W    = 16;
  localparam int              FETCH_INSTR_W   = 18;
  localparam int              FETCH_RAS_DEPTH = 4;
  localparam logic [15:0]     FETCH_RESET_PC  = 16'h0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with a registered top-of-stack value.
// A push while full silently overwrites the oldest entry.
module return_addr_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] entries [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(RAS_DEPTH));

  // ptr always addresses the current top; push+pop rewrites it in place
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      top   <= '0;
    end else if (push && pop) begin
      entries[ptr] <= push_data;
      top          <= push_data;
    end else if (push) begin
      entries[ptr + PTR_W'(1)] <= push_data;
      ptr                      <= ptr + PTR_W'(1);
      top                      <= push_data;
      if (!full) begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      top   <= entries[ptr - PTR_W'(1)];
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter owner: fetches instruction words over req/ack, hands them
// to decode over valid/ready and selects the next PC (seq, redirect, CALL, RET).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = FETCH_ADDR_W,
  parameter int                INSTR_W   = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FETCH_RESET_PC),
  parameter int                RAS_DEPTH = FETCH_RAS_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               call,
  input  logic               ret,
  input  logic               flush,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              squash, squash_n;
  logic              mem_req_n;
  logic              capture;
  logic              push, pop;
  logic              set_ovf, set_unf;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full;
  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc      = instr_pc + ADDR_W'(1);
  assign mem_addr    = pc;
  assign instr_valid = (state == VALID);

  return_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .DATA_W    (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // REQ with mem_req low is the single idle cycle right after reset
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    squash_n = squash;
    capture  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    case (state)
      REQ: begin
        if (mem_req) begin
          if (flush) begin
            if (!mem_ack) begin
              state_n  = WAIT;
              squash_n = 1'b1;
            end
          end else if (mem_ack) begin
            capture = 1'b1;
            state_n = VALID;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (squash || flush) begin
            squash_n = 1'b0;
            state_n  = REQ;
          end else begin
            capture = 1'b1;
            state_n = VALID;
          end
        end else if (flush) begin
          squash_n = 1'b1;
        end
      end
      VALID: begin
        if (flush) begin
          pc_n    = instr_pc;
          state_n = REQ;
        end else if (instr_ready) begin
          state_n = REQ;
          if (ret && !call) begin
            pop     = 1'b1;
            pc_n    = ras_empty ? RESET_PC : ras_top;
            set_unf = ras_empty;
          end else if (redirect) begin
            pc_n = redirect_addr;
            if (call) begin
              // call+ret together replaces the top entry in place
              push    = 1'b1;
              pop     = ret;
              set_ovf = ras_full && !ret;
            end
          end else begin
            pc_n = seq_pc;
          end
        end
      end
      default: state_n = REQ;
    endcase
    mem_req_n = (state_n != VALID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= REQ;
      pc            <= RESET_PC;
      squash        <= 1'b0;
      mem_req       <= 1'b0;
      instr         <= '0;
      instr_pc      <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      squash  <= squash_n;
      mem_req <= mem_req_n;
      if (capture) begin
        instr    <= mem_rdata;
        instr_pc <= pc;
      end
      if (set_ovf) ras_overflow  <= 1'b1;
      if (set_unf) ras_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory returns word = address with a
// programmable ack delay; expected PCs and flags are hand-computed.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [17:0] mem_rdata;
  logic [17:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        call;
  logic        ret;
  logic        flush;
  logic        ras_overflow;
  logic        ras_underflow;

  int errorCount = 0;
  int checkCount = 0;
  int ackDelay   = 0;
  int waitCnt    = 0;
  int reqCyc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .call          (call),
    .ret           (ret),
    .flush         (flush),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // Memory model: acks after ackDelay request cycles, data = address
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (waitCnt >= ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = {2'b00, mem_addr};
          waitCnt   = 0;
        end else begin
          mem_ack = 1'b0;
          waitCnt++;
        end
      end else begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a VALID negedge; returns at the following negedge
  task automatic applyStimulus(input logic rd, input logic c, input logic r,
                               input logic [15:0] addr, input int nextDelay);
    instr_ready   = 1'b1;
    redirect      = rd;
    call          = c;
    ret           = r;
    redirect_addr = addr;
    ackDelay      = nextDelay;
    @(negedge clk);
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    call          = 1'b0;
    ret           = 1'b0;
    redirect_addr = '0;
  endtask

  // Starts at a REQ negedge, ends at the negedge where instr_valid is seen
  task automatic fetchOne(input logic [15:0] expAddr, input string tag,
                          output int reqCycles);
    int n = 0;
    reqCycles = 0;
    checkOutput({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    checkOutput({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, expAddr});
    while (!instr_valid && n < 20) begin
      if (mem_req) reqCycles++;
      if (mem_addr !== expAddr)
        checkOutput({tag, "_addr_steady"}, {16'd0, mem_addr}, {16'd0, expAddr});
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    checkOutput({tag, "_ipc"}, {16'd0, instr_pc}, {16'd0, expAddr});
    checkOutput({tag, "_instr"}, {14'd0, instr}, {16'd0, expAddr});
    checkOutput({tag, "_noreq"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    call          = 1'b0;
    ret           = 1'b0;
    flush         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_addr", {16'd0, mem_addr}, 32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ras_overflow}, 32'd0);
    checkOutput("rst_unf", {31'd0, ras_underflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait sequential fetch: one request cycle per instruction
    for (int k = 0; k < 5; k++) begin
      fetchOne(16'(k), "seq", reqCyc);
      checkOutput("seq_reqcyc", reqCyc, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, (k == 4) ? 3 : 0);
    end

    // Three-cycle ack delay at address 5
    fetchOne(16'h0005, "slow", reqCyc);
    checkOutput("slow_reqcyc", reqCyc, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 0);
    fetchOne(16'h0006, "after_slow", reqCyc);

    // CALL at 10 to 0x200, then RET back to 11
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h000A, 0);
    fetchOne(16'h000A, "jmp10", reqCyc);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0200, 0);
    fetchOne(16'h0200, "call200", reqCyc);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0);
    fetchOne(16'h000B, "ret11", reqCyc);

    // Five nested calls overflow a 4-deep stack
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0100, 0);
    fetchOne(16'h0100, "c1", reqCyc);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0110, 0);
    fetchOne(16'h0110, "c2", reqCyc);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0120, 0);
    fetchOne(16'h0120, "c3", reqCyc);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0130, 0);
    fetchOne(16'h0130, "c4", reqCyc);
    checkOutput("ovf_before", {31'd0, ras_overflow}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0140, 0);
    checkOutput("ovf_after", {31'd0, ras_overflow}, 32'd1);
    fetchOne(16'h0140, "c5", reqCyc);

    // Unwind: 0x131, 0x121, 0x111, 0x101, then underflow to RESET_PC
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0);
    fetchOne(16'h0131, "r1", reqCyc);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0);
    fetchOne(16'h0121, "r2", reqCyc);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0);
    fetchOne(16'h0111, "r3", reqCyc);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0);
    fetchOne(16'h0101, "r4", reqCyc);
    checkOutput("unf_before", {31'd0, ras_underflow}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 0);
    checkOutput("unf_after", {31'd0, ras_underflow}, 32'd1);
    fetchOne(16'h0000, "r5", reqCyc);

    // Flush during WAIT at 8: the late data must be dropped
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0008, 3);
    checkOutput("fw_addr", {16'd0, mem_addr}, 32'h8);
    @(negedge clk);
    checkOutput("fw_waitreq", {31'd0, mem_req}, 32'd1);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush = 1'b0;
      checkOutput("fw_novalid", {31'd0, instr_valid}, 32'd0);
    end
    checkOutput("fw_rereq", {31'd0, mem_req}, 32'd1);
    fetchOne(16'h0008, "fw_refetch", reqCyc);
    checkOutput("fw_reqcyc", reqCyc, 32'd4);

    // Flush in VALID at 12: refetch the same address
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h000C, 0);
    fetchOne(16'h000C, "fv", reqCyc);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("fv_drop", {31'd0, instr_valid}, 32'd0);
    fetchOne(16'h000C, "fv_refetch", reqCyc);

    // PC wrap from 0xFFFF to 0
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF, 0);
    fetchOne(16'hFFFF, "wrapsrc", reqCyc);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 0);
    fetchOne(16'h0000, "wrap", reqCyc);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 0);
    fetchOne(16'h0001, "wrap1", reqCyc);

    // Reset while waiting on address 2
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 5);
    checkOutput("rw_addr", {16'd0, mem_addr}, 32'h2);
    @(negedge clk);
    checkOutput("rw_wait", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    ackDelay = 0;
    checkOutput("rw_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rw_pc", {16'd0, mem_addr}, 32'd0);
    checkOutput("rw_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rw_instr", {14'd0, instr}, 32'd0);
    checkOutput("rw_ipc", {16'd0, instr_pc}, 32'd0);
    checkOutput("rw_ovf", {31'd0, ras_overflow}, 32'd0);
    checkOutput("rw_unf", {31'd0, ras_underflow}, 32'd0);
    @(negedge clk);
    fetchOne(16'h0000, "rw_restart", reqCyc);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
